part1_test: RTL and testbench
=============================

Name: part1_test

Overview:
- Minimal single-cycle 8-bit microprocessor with a hardwired program ROM.
- Holds a 4x8 register file, an ALU, a PC and an 8-bit output port latched onto `display`.
- Used as the part-1 bring-up core of the microprocessor project.
- Needs no inputs other than clock and reset; correctness is judged entirely from the `display` sequence.

Parameters:
- None. Data width is 8, instruction width is 16, ROM depth is 32 words, register count is 4; all fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- display  output  8  output register, written only by OUT.

Behaviour:
- Reset (reset=0, async):
  - PC=0, R0..R3=0x00, display=0x00, halted=0.
  - Held for as long as reset is low; re-asserting mid-program restarts from address 0.
- Execution:
  - Each rising edge with reset=1 and halted=0 executes exactly one instruction ROM[PC].
  - PC <= PC+1 unless a jump or branch is taken.
  - PC is 5 bits and wraps 31->0.
- Instruction format: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm. Opcodes:
  - 0 NOP.
  - 1 LDI: rd <= imm.
  - 2 ADD: rd <= rd+rs. 3 SUB: rd <= rd-rs. Both modulo 256; no flags.
  - 4 AND: rd <= rd&rs. 5 OR. 6 XOR.
  - 7 MOV: rd <= rs.
  - 8 OUT: display <= R[rs], updated on the same edge.
  - 9 JMP: PC <= imm[4:0].
  - A BEQZ: if R[rs]==0 then PC <= imm[4:0], else PC+1.
  - F HALT: halted <= 1. PC and all state freeze until reset.
  - B-E: treated as NOP.
- Register reads use pre-edge values; e.g. SUB R0,R0 yields 0.
- display holds its last value between OUTs and after HALT.
- ROM contents (unlisted addresses = 0x0000 NOP):
  - 0: 0x1005 LDI R0,0x05
  - 1: 0x8000 OUT R0
  - 2: 0x1401 LDI R1,0x01
  - 3: 0x3100 SUB R0,R1
  - 4: 0xA006 BEQZ R0,6
  - 5: 0x9001 JMP 1
  - 6: 0x18AA LDI R2,0xAA
  - 7: 0x8200 OUT R2
  - 8: 0xF000 HALT
- Timing, with edges counted from the first rising edge after reset goes high:
  - display becomes 05, 04, 03, 02, 01 at edges 2, 7, 12, 17, 22.
  - R0 reaches 0 at edge 24; BEQZ is taken at edge 25.
  - display becomes 0xAA at edge 27.
  - HALT executes at edge 28; PC stays 8 forever after.
  - 0x00 is never output by the program.

Test Plan:
- Reset for 50 ns with 20 ns clock period, then release -> display=0x00 during reset and at edge 1; display=0x05 after edge 2.
- Run 30 edges, logging display changes -> exact sequence 05,04,03,02,01,AA at edges 2/7/12/17/22/27; no other changes.
- Run 100 further edges after HALT -> display stays 0xAA; internal PC stays 8; R0=0x00, R1=0x01, R2=0xAA, R3=0x00.
- Assert reset asynchronously mid-loop (e.g. after edge 13, between edges) -> display=0x00 immediately without a clock edge; after release the sequence restarts from 05 at edge 2.
- Assert reset while halted, then release -> full sequence repeats identically, proving the halt state clears.
- Glitch-free check -> display never changes on a falling edge and never changes while reset is low.

Source files
------------

// File: rtl/part1_test.sv
// part1_test: single-cycle 8-bit bring-up core with a hardwired 32-word program ROM.
// It has a 4x8 register file, an ALU, a 5-bit PC and an 8-bit output register.
//
// Ports:
//   clk      input   1  system clock; all state changes on the rising edge
//   reset    input   1  asynchronous active-low reset
//   display  output  8  output register, written only by the OUT instruction
//
// Core state:
//   state   | meaning
//   ST_RUN  | executes ROM[PC] on every rising edge
//   ST_HALT | HALT has executed; PC, registers and display stay frozen until reset
//
// Instruction word: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.

module part1_test (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] display
);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BEQZ = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  logic [4:0]  r_pc;
  logic [7:0]  r_regs [4];
  logic [7:0]  r_display;

  logic [15:0] w_instr;
  logic [3:0]  w_opcode;
  logic [1:0]  w_rd;
  logic [1:0]  w_rs;
  logic [7:0]  w_imm;
  logic [7:0]  w_rd_val;
  logic [7:0]  w_rs_val;
  logic [7:0]  w_alu;
  logic        w_wr_en;
  logic        w_out_en;
  logic        w_halt;
  logic [4:0]  w_pc_inc;
  logic [4:0]  w_pc_next;

  // Program ROM: count R0 down from 5, outputting each value, then output 0xAA and halt.
  always_comb begin
    w_instr = 16'h0000;
    case (r_pc)
      5'd0:    w_instr = 16'h1005;  // LDI  R0,0x05
      5'd1:    w_instr = 16'h8000;  // OUT  R0
      5'd2:    w_instr = 16'h1401;  // LDI  R1,0x01
      5'd3:    w_instr = 16'h3100;  // SUB  R0,R1
      5'd4:    w_instr = 16'hA006;  // BEQZ R0,6
      5'd5:    w_instr = 16'h9001;  // JMP  1
      5'd6:    w_instr = 16'h18AA;  // LDI  R2,0xAA
      5'd7:    w_instr = 16'h8200;  // OUT  R2
      5'd8:    w_instr = 16'hF000;  // HALT
      default: w_instr = 16'h0000;
    endcase
  end

  assign w_opcode = w_instr[15:12];
  assign w_rd     = w_instr[11:10];
  assign w_rs     = w_instr[9:8];
  assign w_imm    = w_instr[7:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  // 5-bit add wraps 31 -> 0 naturally.
  assign w_pc_inc = r_pc + 5'd1;

  // Decode and ALU; all operands are the pre-edge register values.
  always_comb begin
    w_alu     = 8'h00;
    w_wr_en   = 1'b0;
    w_out_en  = 1'b0;
    w_halt    = 1'b0;
    w_pc_next = w_pc_inc;
    case (w_opcode)
      OP_LDI: begin
        w_alu   = w_imm;
        w_wr_en = 1'b1;
      end
      OP_ADD: begin
        w_alu   = w_rd_val + w_rs_val;
        w_wr_en = 1'b1;
      end
      OP_SUB: begin
        w_alu   = w_rd_val - w_rs_val;
        w_wr_en = 1'b1;
      end
      OP_AND: begin
        w_alu   = w_rd_val & w_rs_val;
        w_wr_en = 1'b1;
      end
      OP_OR: begin
        w_alu   = w_rd_val | w_rs_val;
        w_wr_en = 1'b1;
      end
      OP_XOR: begin
        w_alu   = w_rd_val ^ w_rs_val;
        w_wr_en = 1'b1;
      end
      OP_MOV: begin
        w_alu   = w_rs_val;
        w_wr_en = 1'b1;
      end
      OP_OUT:  w_out_en = 1'b1;
      OP_JMP:  w_pc_next = w_imm[4:0];
      OP_BEQZ: begin
        if (w_rs_val == 8'h00) w_pc_next = w_imm[4:0];
      end
      OP_HALT: begin
        // PC stays on the HALT instruction.
        w_halt    = 1'b1;
        w_pc_next = r_pc;
      end
      default: ;  // NOP and unused opcodes B-E
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_pc      <= 5'd0;
      r_display <= 8'h00;
      for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_pc <= w_pc_next;
          if (w_wr_en)  r_regs[w_rd] <= w_alu;
          if (w_out_en) r_display    <= w_rs_val;
          if (w_halt)   r_state      <= ST_HALT;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign display = r_display;

endmodule

// File: tb/tb_part1_test.sv
module tb_part1_test;

  logic       clk;
  logic       reset;
  logic [7:0] display;

  int checks;
  int errors;
  int glitches;

  typedef struct {
    int         edge_n;
    logic [7:0] value;
  } disp_vec_t;

  disp_vec_t vecs [6];

  part1_test dut (
    .clk     (clk),
    .reset   (reset),
    .display (display)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // display may only change on a rising edge with reset high, or drop to 0 on reset assertion.
  always @(display) begin
    if ($time > 0) begin
      if ((clk === 1'b0 && reset === 1'b1) || (reset === 1'b0 && display !== 8'h00))
        glitches++;
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs n_edges edges from a fresh reset release and compares display after each edge
  // against the change table.
  task automatic run_sequence(input string tag, input int n_edges);
    logic [7:0] exp;
    int k;
    exp = 8'h00;
    k = 0;
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1;
      if (k < 6 && vecs[k].edge_n == e) begin
        exp = vecs[k].value;
        k++;
      end
      check8($sformatf("%s_disp_edge%0d", tag, e), display, exp);
      if (e >= 28) check8($sformatf("%s_pc_edge%0d", tag, e), {3'b000, dut.r_pc}, 8'd8);
    end
  endtask

  task automatic check_halted(input string tag, input int n_edges);
    for (int e = 0; e < n_edges; e++) begin
      @(posedge clk);
      #1;
      check8($sformatf("%s_hold_disp%0d", tag, e), display, 8'hAA);
      check8($sformatf("%s_hold_pc%0d", tag, e), {3'b000, dut.r_pc}, 8'd8);
    end
    check8({tag, "_r0"}, dut.r_regs[0], 8'h00);
    check8({tag, "_r1"}, dut.r_regs[1], 8'h01);
    check8({tag, "_r2"}, dut.r_regs[2], 8'hAA);
    check8({tag, "_r3"}, dut.r_regs[3], 8'h00);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    glitches = 0;

    vecs[0] = '{2,  8'h05};
    vecs[1] = '{7,  8'h04};
    vecs[2] = '{12, 8'h03};
    vecs[3] = '{17, 8'h02};
    vecs[4] = '{22, 8'h01};
    vecs[5] = '{27, 8'hAA};

    // Power-on reset: held across several edges.
    reset = 1'b0;
    #50;
    check8("reset_disp", display, 8'h00);
    check8("reset_pc", {3'b000, dut.r_pc}, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    run_sequence("run1", 30);
    check_halted("run1", 100);

    // Async reset mid-loop, between edges 13 and 14.
    @(negedge clk);
    reset = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
    run_sequence("pre", 13);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check8("async_disp", display, 8'h00);
    check8("async_pc", {3'b000, dut.r_pc}, 8'd0);
    check8("async_r0", dut.r_regs[0], 8'h00);
    check8("async_r1", dut.r_regs[1], 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      check8("held_disp", display, 8'h00);
      check8("held_pc", {3'b000, dut.r_pc}, 8'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    run_sequence("run2", 30);
    check_halted("run2", 10);

    // Reset while halted must clear the halt state.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check8("halt_rst_disp", display, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    run_sequence("run3", 30);
    check_halted("run3", 10);

    checks++;
    if (glitches != 0) begin
      errors++;
      $display("FAIL glitch_monitor: got %0d bad display changes expected 0", glitches);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
